// File: rtl/ram_pkg.sv
// Shared types and helpers for the clearable single-port RAM.
// Holds the FSM state enum and the lane-count helpers.
package ram_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_e;

  function automatic int nlanes(input int data_w, input int lane_w);
    return data_w / lane_w;
  endfunction

  function automatic bit lanes_ok(input int data_w, input int lane_w);
    return (lane_w > 0) && (data_w % lane_w == 0);
  endfunction

endpackage

// File: rtl/ram_clr_fsm.sv
// Clear sequencer and request accept/reject decode for ram_clr_sp.
// In: clk, rst, w_i, r_i, clr_i. Out: busy_o, acc_w_o, acc_r_o, clr_we_o, clr_ad_o, err_o.
module ram_clr_fsm
  import ram_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter bit INIT_ON_RST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_i,
  input  logic              r_i,
  input  logic              clr_i,
  output logic              busy_o,
  output logic              acc_w_o,
  output logic              acc_r_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_ad_o,
  output logic              err_o
);

  localparam state_e RstSt = INIT_ON_RST ? ST_CLEAR : ST_IDLE;
  localparam logic [ADDR_W-1:0] CntMax = '1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              acc_w, acc_r, clr_we;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    acc_w   = 1'b0;
    acc_r   = 1'b0;
    clr_we  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (clr_i) begin
          state_d = ST_CLEAR;
          err_d   = w_i | r_i;
        end else begin
          acc_w = w_i;
          acc_r = r_i;
        end
      end
      ST_CLEAR: begin
        clr_we = 1'b1;
        err_d  = w_i | r_i | clr_i;
        if (cnt_q == CntMax) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
    // Reset must never touch the array, so gate every write strobe.
    if (rst) begin
      acc_w  = 1'b0;
      acc_r  = 1'b0;
      clr_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RstSt;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign busy_o   = (state_q == ST_CLEAR);
  assign acc_w_o  = acc_w;
  assign acc_r_o  = acc_r;
  assign clr_we_o = clr_we;
  assign clr_ad_o = cnt_q;
  assign err_o    = err_q;

endmodule

// File: rtl/ram_clr_sp.sv
// Single-port RAM with lane write enables, registered read and clear engine.
// In: clk, rst, w, r, be, ad, d_i, clr. Out: d_o, d_v, busy, err.
module ram_clr_sp
  import ram_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int LANE_W      = 4,
  parameter bit INIT_ON_RST = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            w,
  input  logic                            r,
  input  logic [nlanes(DATA_W,LANE_W)-1:0] be,
  input  logic [ADDR_W-1:0]               ad,
  input  logic [DATA_W-1:0]               d_i,
  input  logic                            clr,
  output logic [DATA_W-1:0]               d_o,
  output logic                            d_v,
  output logic                            busy,
  output logic                            err
);

  localparam int NL    = nlanes(DATA_W, LANE_W);
  localparam int DEPTH = 2 ** ADDR_W;

  if (!lanes_ok(DATA_W, LANE_W)) begin : g_bad_lanes
    $error("DATA_W must be a multiple of LANE_W");
  end

  logic              acc_w, acc_r, clr_we;
  logic [ADDR_W-1:0] clr_ad;

  ram_clr_fsm #(
    .ADDR_W      (ADDR_W),
    .INIT_ON_RST (INIT_ON_RST)
  ) u_fsm (
    .clk      (clk),
    .rst      (rst),
    .w_i      (w),
    .r_i      (r),
    .clr_i    (clr),
    .busy_o   (busy),
    .acc_w_o  (acc_w),
    .acc_r_o  (acc_r),
    .clr_we_o (clr_we),
    .clr_ad_o (clr_ad),
    .err_o    (err)
  );

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_word, merged;
  logic [DATA_W-1:0] d_o_q, d_o_d;
  logic              d_v_q;

  assign rd_word = mem_q[ad];

  always_comb begin
    merged = rd_word;
    for (int i = 0; i < NL; i++) begin
      if (be[i]) begin
        merged[i*LANE_W +: LANE_W] = d_i[i*LANE_W +: LANE_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_ad] <= '0;
    end else if (acc_w) begin
      mem_q[ad] <= merged;
    end
  end

  // Write-first: a same-cycle read returns the merged word.
  always_comb begin
    d_o_d = d_o_q;
    if (acc_r) begin
      d_o_d = acc_w ? merged : rd_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_o_q <= '0;
      d_v_q <= 1'b0;
    end else begin
      d_o_q <= d_o_d;
      d_v_q <= acc_r;
    end
  end

  assign d_o = d_o_q;
  assign d_v = d_v_q;

endmodule
